ysyx_24090012_ifid_queue: RTL and testbench
===========================================

Name: ysyx_24090012_ifid_queue

Overview:
- Decoupling buffer between the IFU and IDU. Accepts fetched {pc, inst, num} over a valid/ready handshake and holds them in a small FIFO.
- Pre-decodes control-flow class and static target at enqueue, so the IDU reads them as registered data.
- A flush on a control hazard discards every queued entry in one cycle.
- Breaks the IFU-to-IDU combinational ready path: in_ready never depends on out_ready.

Parameters:
- DEPTH, 2, number of entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width.
- FENCE_I_INST, 32'h0000100F, exact encoding recognised as fence.i.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- in_valid  in  1  IFU presents an instruction.
- in_ready  out  1  queue accepts an instruction this cycle.
- in_pc  in  32  instruction PC.
- in_inst  in  32  instruction word.
- in_num  in  64  instruction sequence number.
- flush  in  1  control hazard: discard all entries and the current input.
- out_valid  out  1  head entry valid.
- out_ready  in  1  IDU consumes the head.
- out_pc  out  32  head PC.
- out_inst  out  32  head instruction.
- out_num  out  64  head sequence number.
- out_is_branch  out  1  opcode 1100011.
- out_is_jal  out  1  opcode 1101111.
- out_is_jalr  out  1  opcode 1100111.
- out_is_fence_i  out  1  inst == FENCE_I_INST.
- out_target  out  32  pc+B-imm (branch), pc+J-imm (jal), else 0.
- occupancy  out  PTR_W+1  entries held.
- flush_drop_cnt  out  32  total entries discarded by flush.

Behaviour:
- Reset (reset==0, asynchronous):
  - Pointers, occupancy and flush_drop_cnt go to 0.
  - out_valid goes to 0; in_ready is 1 once reset is released.
  - Entry payloads are don't-care, but out_* data fields read 0 while out_valid==0.
- Enqueue: in_valid && in_ready at the rising edge writes the entry at wr_ptr. The entry holds pc, inst, num, the 4 class bits and target.
- Dequeue: out_valid && out_ready at the rising edge advances rd_ptr.
- Readiness and validity:
  - in_ready = (occupancy < DEPTH) && !flush. It is purely a function of registered state and flush.
  - out_valid = (occupancy != 0). out_* is the entry at rd_ptr, read combinationally from registered storage.
- Latency: an accepted instruction is visible at out_* in the next cycle. There is no same-cycle bypass.
- Simultaneous enqueue and dequeue: both happen and occupancy is unchanged. This is legal at any occupancy, including DEPTH-1.
- Full (occupancy==DEPTH): in_ready=0 even if out_ready=1 that cycle. Entries are held unchanged.
- Empty: out_valid=0 and out_ready is ignored. occupancy never underflows.
- Pointers wrap modulo DEPTH. occupancy saturates at neither end by construction, because handshakes prevent overflow.
- Flush (synchronous, highest priority), on the next edge:
  - rd_ptr := wr_ptr and occupancy := 0.
  - The in_valid beat is not accepted, because in_ready is already 0.
  - A dequeue in the same cycle is still counted as consumed by the IDU.
  - flush_drop_cnt += occupancy minus (1 if a dequeue handshake occurred), wrapping modulo 2^32.
- Flush while empty: no effect except the blocked input.
- Pre-decode, combinational at enqueue, stored with the entry:
  - Immediates are sign-extended to 32 bits.
  - B-imm = {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - J-imm = {inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - Addition is modulo 2^32.
  - At most one class bit is set per entry.
- Reset asserted mid-operation: all contents are lost immediately. There are no partial outputs after release.

Decomposition:
- Shared package ysyx_24090012_pkg holds:
  - the opcode constants OPC_BRANCH, OPC_JAL, OPC_JALR;
  - FENCE_I_INST;
  - a packed entry typedef {pc, inst, num, is_branch, is_jal, is_jalr, is_fence_i, target}.
- One sub-module: ysyx_24090012_predecode, purely combinational, inst+pc in, class bits + target out. The top instantiates it on the input side only.

Test Plan:
- Reset release, then push pc=0x80000000 inst=0x00000013 num=1 with out_ready=0. Next cycle: out_valid=1, out_pc=0x80000000, is_* all 0, target=0, occupancy=1.
- With out_ready=0, push 2 entries. Required: occupancy=2, in_ready=0. A third in_valid is not accepted even with out_ready=1 that cycle. The next push succeeds one cycle later.
- Streaming with in_valid=out_ready=1 for 10 cycles. Required: occupancy constant, out_num increments by 1 each cycle, no bubbles after the first.
- Push jal at pc=0x80000010 inst=0xFF9FF06F. Required: is_jal=1, target=0x80000008. Push beq inst=0x00000463 at pc=0x80000020. Required: is_branch=1, target=0x80000028.
- Occupancy=2, assert flush with in_valid=1 and out_ready=1. Next cycle: out_valid=0, occupancy=0, flush_drop_cnt=1. The input beat is discarded.
- Push inst=0x0000100F and confirm is_fence_i=1. Assert reset (drive 0) asynchronously mid-cycle with occupancy=1. Required: out_valid drops immediately and flush_drop_cnt=0.

Source files
------------

// File: rtl/ysyx_24090012_pkg.sv
// ysyx_24090012_pkg: shared opcodes and the queued entry layout for the IF/ID queue
package ysyx_24090012_pkg;
  localparam logic [6:0]  OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0]  OPC_JAL      = 7'b1101111;
  localparam logic [6:0]  OPC_JALR     = 7'b1100111;
  localparam logic [31:0] FENCE_I_INST = 32'h0000100F;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [63:0] num;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        is_fence_i;
    logic [31:0] target;
  } entry_t;
endpackage

// File: rtl/ysyx_24090012_predecode.sv
// ysyx_24090012_predecode: control-flow class and static target of one instruction
module ysyx_24090012_predecode
  import ysyx_24090012_pkg::*;
#(
  parameter logic [31:0] FENCE_I = ysyx_24090012_pkg::FENCE_I_INST
) (
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  output logic        is_branch_o,
  output logic        is_jal_o,
  output logic        is_jalr_o,
  output logic        is_fence_i_o,
  output logic [31:0] target_o
);
  logic [31:0] b_imm, j_imm;
  always_comb begin
    b_imm        = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    j_imm        = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    is_branch_o  = inst_i[6:0] == OPC_BRANCH;
    is_jal_o     = inst_i[6:0] == OPC_JAL;
    is_jalr_o    = inst_i[6:0] == OPC_JALR;
    is_fence_i_o = inst_i == FENCE_I;
    target_o     = is_branch_o ? pc_i + b_imm : is_jal_o ? pc_i + j_imm : '0;
  end
endmodule

// File: rtl/ysyx_24090012_ifid_queue.sv
// ysyx_24090012_ifid_queue: IFU-to-IDU decoupling FIFO with enqueue-time pre-decode and one-cycle flush
module ysyx_24090012_ifid_queue
  import ysyx_24090012_pkg::*;
#(
  parameter int          DEPTH        = 2,
  parameter int          PTR_W        = $clog2(DEPTH),
  parameter logic [31:0] FENCE_I_INST = ysyx_24090012_pkg::FENCE_I_INST
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst,
  input  logic [63:0]      in_num,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  output logic [63:0]      out_num,
  output logic             out_is_branch,
  output logic             out_is_jal,
  output logic             out_is_jalr,
  output logic             out_is_fence_i,
  output logic [31:0]      out_target,
  output logic [PTR_W:0]   occupancy,
  output logic [31:0]      flush_drop_cnt
);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  entry_t           mem_q [DEPTH];
  entry_t           in_ent, head;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   occ_q, occ_d;
  logic [31:0]      drop_q, drop_d;
  logic             enq, deq;
  logic             pd_branch, pd_jal, pd_jalr, pd_fence_i;
  logic [31:0]      pd_target;
  ysyx_24090012_predecode #(.FENCE_I(FENCE_I_INST)) u_predecode (
    .inst_i      (in_inst),
    .pc_i        (in_pc),
    .is_branch_o (pd_branch),
    .is_jal_o    (pd_jal),
    .is_jalr_o   (pd_jalr),
    .is_fence_i_o(pd_fence_i),
    .target_o    (pd_target)
  );
  // in_ready looks only at registered occupancy and flush, never at out_ready
  always_comb begin
    in_ready  = occ_q != FULL && !flush;
    out_valid = occ_q != '0;
    enq       = in_valid && in_ready;
    deq       = out_valid && out_ready;
    in_ent    = '{pc: in_pc, inst: in_inst, num: in_num, is_branch: pd_branch, is_jal: pd_jal,
                  is_jalr: pd_jalr, is_fence_i: pd_fence_i, target: pd_target};
    head      = out_valid ? mem_q[rd_ptr_q] : '0;
    wr_ptr_d  = wr_ptr_q + PTR_W'(enq);
    rd_ptr_d  = flush ? wr_ptr_q : rd_ptr_q + PTR_W'(deq);
    occ_d     = flush ? '0 : occ_q + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);
    drop_d    = flush ? drop_q + 32'(occ_q) - 32'(deq) : drop_q;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      drop_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      drop_q   <= drop_d;
    end
  end
  always_ff @(posedge clock) begin
    if (enq) mem_q[wr_ptr_q] <= in_ent;
  end
  assign out_pc         = head.pc;
  assign out_inst       = head.inst;
  assign out_num        = head.num;
  assign out_is_branch  = head.is_branch;
  assign out_is_jal     = head.is_jal;
  assign out_is_jalr    = head.is_jalr;
  assign out_is_fence_i = head.is_fence_i;
  assign out_target     = head.target;
  assign occupancy      = occ_q;
  assign flush_drop_cnt = drop_q;
endmodule

// File: tb/tb_ysyx_24090012_ifid_queue.sv
// tb_ysyx_24090012_ifid_queue: queue-model scoreboard plus directed literal checks
module tb_ysyx_24090012_ifid_queue;
  localparam int DEPTH = 2;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [63:0] num;
    logic        br, jal, jalr, fi;
    logic [31:0] tgt;
  } tb_ent_t;
  logic        clock = 0, reset = 0;
  logic        in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 0;
  logic [31:0] in_pc = 0, in_inst = 0, out_pc, out_inst, out_target, flush_drop_cnt;
  logic [63:0] in_num = 0, out_num;
  logic        out_is_branch, out_is_jal, out_is_jalr, out_is_fence_i;
  logic [1:0]  occupancy;
  int          checks = 0, errors = 0;
  tb_ent_t     mq[$];
  logic [31:0] mdrop = 0;
  ysyx_24090012_ifid_queue dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .in_num(in_num), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_num(out_num), .out_is_branch(out_is_branch),
    .out_is_jal(out_is_jal), .out_is_jalr(out_is_jalr), .out_is_fence_i(out_is_fence_i),
    .out_target(out_target), .occupancy(occupancy), .flush_drop_cnt(flush_drop_cnt)
  );
  always #5 clock = ~clock;
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", n, got, exp, $time);
    end
  endtask
  // Immediates assembled arithmetically from their bit weights
  function automatic tb_ent_t mk(input logic [31:0] pc, input logic [31:0] inst, input logic [63:0] num);
    tb_ent_t e;
    int b, j;
    b = (inst[31] ? -4096 : 0) + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
    j = (inst[31] ? -1048576 : 0) + int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
    e.pc = pc;
    e.inst = inst;
    e.num = num;
    e.br = inst[6:0] == 7'h63;
    e.jal = inst[6:0] == 7'h6F;
    e.jalr = inst[6:0] == 7'h67;
    e.fi = inst == 32'h0000100F;
    e.tgt = e.br ? pc + 32'(b) : e.jal ? pc + 32'(j) : 32'h0;
    return e;
  endfunction
  always @(posedge clock or negedge reset) begin
    bit d, e;
    if (!reset) begin
      mq.delete();
      mdrop = 0;
    end else begin
      d = mq.size() != 0 && out_ready;
      e = in_valid && !flush && mq.size() < DEPTH;
      if (flush) begin
        mdrop = mdrop + 32'(mq.size()) - 32'(d);
        mq.delete();
      end else begin
        if (d) void'(mq.pop_front());
        if (e) mq.push_back(mk(in_pc, in_inst, in_num));
      end
    end
  end
  always @(negedge clock) begin
    tb_ent_t h;
    if (reset) begin
      h = mq.size() != 0 ? mq[0] : '0;
      chk("m_out_valid", out_valid, mq.size() != 0);
      chk("m_in_ready", in_ready, mq.size() < DEPTH && !flush);
      chk("m_occupancy", occupancy, mq.size());
      chk("m_drop_cnt", flush_drop_cnt, mdrop);
      chk("m_out_pc", out_pc, h.pc);
      chk("m_out_inst", out_inst, h.inst);
      chk("m_out_num", out_num, h.num);
      chk("m_class", {out_is_branch, out_is_jal, out_is_jalr, out_is_fence_i}, {h.br, h.jal, h.jalr, h.fi});
      chk("m_target", out_target, h.tgt);
    end
  end
  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                     input logic [63:0] num, input logic ordy, input logic fl);
    in_valid = v; in_pc = pc; in_inst = inst; in_num = num; out_ready = ordy; flush = fl;
    @(posedge clock);
    #1;
    in_valid = 0; out_ready = 0; flush = 0;
  endtask
  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_occ", occupancy, 0);
    chk("rst_drop", flush_drop_cnt, 0);
    chk("rst_out_pc", out_pc, 0);
    cyc(1, 32'h80000000, 32'h00000013, 1, 0, 0);
    chk("p1_valid", out_valid, 1);
    chk("p1_pc", out_pc, 32'h80000000);
    chk("p1_class", {out_is_branch, out_is_jal, out_is_jalr, out_is_fence_i}, 0);
    chk("p1_target", out_target, 0);
    chk("p1_occ", occupancy, 1);
    cyc(0, 0, 0, 0, 1, 0);
    chk("drain_occ", occupancy, 0);
    cyc(1, 32'h80000004, 32'h00000013, 2, 0, 0);
    cyc(1, 32'h80000008, 32'h00000013, 3, 0, 0);
    chk("full_occ", occupancy, 2);
    chk("full_in_ready", in_ready, 0);
    cyc(1, 32'h8000000C, 32'h00000013, 4, 1, 0);
    chk("full_deq_occ", occupancy, 1);
    chk("full_deq_num", out_num, 3);
    cyc(1, 32'h8000000C, 32'h00000013, 4, 0, 0);
    chk("retry_occ", occupancy, 2);
    chk("retry_head", out_num, 3);
    repeat (2) cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 32'h80000100, 32'h00000013, 10, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      cyc(1, 32'h80000100 + 32'(4 * i), 32'h00000013, 64'(10 + i), 1, 0);
      chk("stream_valid", out_valid, 1);
      chk("stream_num", out_num, 64'(10 + i));
      chk("stream_occ", occupancy, 1);
    end
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 32'h80000010, 32'hFF9FF06F, 30, 0, 0);
    chk("jal_flag", out_is_jal, 1);
    chk("jal_branch", out_is_branch, 0);
    chk("jal_target", out_target, 32'h80000008);
    cyc(1, 32'h80000020, 32'h00000463, 31, 1, 0);
    chk("beq_flag", out_is_branch, 1);
    chk("beq_target", out_target, 32'h80000028);
    cyc(1, 32'h80000030, 32'h000080E7, 32, 0, 0);
    chk("pre_flush_occ", occupancy, 2);
    cyc(1, 32'h80000040, 32'h00000013, 33, 1, 1);
    chk("flush_valid", out_valid, 0);
    chk("flush_occ", occupancy, 0);
    chk("flush_drop", flush_drop_cnt, 1);
    cyc(1, 32'h80000044, 32'h00000013, 34, 1, 1);
    chk("flush_empty_drop", flush_drop_cnt, 1);
    chk("flush_empty_valid", out_valid, 0);
    cyc(1, 32'h80000050, 32'h0000100F, 40, 0, 0);
    chk("fence_flag", out_is_fence_i, 1);
    chk("fence_target", out_target, 0);
    #2 reset = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_occ", occupancy, 0);
    chk("arst_drop", flush_drop_cnt, 0);
    chk("arst_pc", out_pc, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_valid", out_valid, 0);
    cyc(1, 32'h80000060, 32'h00000013, 50, 0, 0);
    cyc(1, 32'h80000064, 32'h00000013, 51, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("flush2_drop", flush_drop_cnt, 2);
    chk("flush2_occ", occupancy, 0);
    cyc(0, 0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
